logicalunit_prober: RTL and testbench
=====================================

Name: logicalunit_prober

Overview:
- Sequential identifier for a 2-input programmable logical unit (out = func[{a,b}]).
- Drives all four (a,b) combinations into the unit under test, waits a settle window for each, samples its output, and rebuilds the 4-bit function code.
- Optionally repeats the sweep and flags any inconsistency between passes.
- Sits beside the logical unit in self-test/characterisation harnesses as its reader counterpart.

Parameters:
- SETTLE_CYCLES, 1, idle cycles per combination before sampling; legal 0..15.
- PASSES, 2, number of full 4-combination sweeps; legal 1..8.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request a probe; sampled only in IDLE.
- abort  input  1  synchronous abort of a running probe.
- resp  input  1  output of the unit under test.
- a  output  1  drive to the unit's a input (index bit 1).
- b  output  1  drive to the unit's b input (index bit 0).
- busy  output  1  high while a probe is running.
- done  output  1  one-cycle pulse when a probe completes.
- valid  output  1  func_code and mismatch hold a completed result.
- func_code  output  4  reconstructed code; bit i = resp sampled at {a,b}=i in pass 0.
- mismatch  output  1  some later pass disagreed with pass 0.

Behaviour:
- Reset (async, rst=1): state=IDLE; a=0, b=0, busy=0, done=0, valid=0, func_code=0, mismatch=0, all counters 0. Reset mid-probe discards everything and emits no done.
- States: IDLE, SWEEP, FINISH.
- IDLE: a=b=0, busy=0. start=1 at edge E0 enters SWEEP.
  - At E0: idx=0, pass=0, settle counter=0, valid<=0, mismatch<=0, busy<=1.
- SWEEP: {a,b}=idx, registered and stable for the whole window. Each index occupies exactly SETTLE_CYCLES+1 cycles.
  - resp is sampled at the last edge of each window.
  - Pass 0: func_code[idx]<=resp.
  - Pass >0: if resp!=func_code[idx], mismatch<=1 (sticky for the probe).
  - Index order per pass: 0,1,2,3. idx wraps 3->0 and pass increments.
- Final sample edge is E0+PASSES*4*(SETTLE_CYCLES+1). At that edge: state->FINISH, busy<=0, done<=1, valid<=1, a=b=0.
- FINISH: lasts one cycle. done drops, state->IDLE.
  - start asserted during FINISH is ignored.
  - start in the next IDLE cycle is accepted.
- start while busy is ignored; it is neither queued nor restarted.
- abort=1 in SWEEP at edge Ex: state->IDLE, busy<=0, a=b=0, valid stays 0, no done pulse.
  - abort has priority over a sample on the same edge.
  - abort in IDLE/FINISH has no effect.
- start and abort both high in IDLE: abort wins and start is dropped.
- Results hold until the next accepted start, which clears valid and mismatch. func_code keeps its old value until overwritten in pass 0.
- SETTLE_CYCLES=0: one cycle per index, sample taken at the edge after the drive edge.

Decomposition:
- Package logicalunit_probe_pkg holds:
  - state enum {IDLE,SWEEP,FINISH};
  - index width constant (2);
  - index-to-drive mapping (a=idx[1], b=idx[0]);
  - a function computing total latency PASSES*4*(SETTLE_CYCLES+1).
- One natural sub-module: settle_timer, a loadable down-counter with a terminal-count pulse. It is reused per index window.

Test Plan:
- Logical unit with func=4'b1010, defaults. start at E0 -> a/b sequence 00,01,10,11 twice, each held 2 cycles; done pulse after E0+16; func_code=1010, mismatch=0, valid=1.
- func=0000, then func=1111, back-to-back probes with start on the first IDLE cycle after FINISH -> func_code 0000 then 1111; valid low between the second start and its done.
- Faulty DUT that inverts resp for {a,b}=2 only in pass 1 -> func_code equals the pass-0 value, mismatch=1, done at E0+16.
- start pulsed at E0+5 while busy, then abort at E0+7 -> no restart; busy=0 after E0+7, a=b=0, no done, valid=0.
- rst asserted asynchronously mid-cycle during SWEEP -> all outputs 0 immediately; a subsequent start probes func=0110 correctly.
- SETTLE_CYCLES=0, PASSES=1, func=1001 -> one cycle per index, done after E0+4, func_code=1001.

Source files
------------

// File: rtl/logicalunit_probe_pkg.sv
// Shared types and helpers for the logical-unit prober.
//   state_t       : controller states
//   drive_t       : {a,b} drive payload toward the unit under test
//   idx_to_drive  : combination index -> {a,b} (a = idx[1], b = idx[0])
//   total_latency : start edge to final sample edge, in cycles
package logicalunit_probe_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;

  localparam int unsigned IDX_W    = 2;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned PASS_W   = 3;

  typedef struct packed {
    logic a;
    logic b;
  } drive_t;

  function automatic drive_t idx_to_drive(input logic [IDX_W-1:0] idx);
    drive_t d;
    d.a = idx[1];
    d.b = idx[0];
    return d;
  endfunction

  function automatic int unsigned total_latency(input int unsigned passes,
                                                input int unsigned settle);
    return passes * 4 * (settle + 1);
  endfunction

endpackage

// File: rtl/logicalunit_prober_settle_timer.sv
// Loadable down-counter timing one settle window.
//   clk, rst   : clock, async active-high reset
//   load       : load load_value (wins over en)
//   en         : count down while nonzero
//   load_value : window length minus one
//   expired_c  : combinational terminal count (count == 0)
module settle_timer
  import logicalunit_probe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                en,
  input  logic [SETTLE_W-1:0] load_value,
  output logic                expired_c
);

  logic [SETTLE_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - SETTLE_W'(1);
    end
  end

  assign expired_c = (count_q == '0);

endmodule

// File: rtl/logicalunit_prober.sv
// Sweeps all four {a,b} combinations into a 2-input logical unit, samples its
// response at the end of each settle window and rebuilds the function code.
//   clk, rst  : clock, async active-high reset
//   start     : request a probe (IDLE only)
//   abort     : cancel a running probe
//   resp      : output of the unit under test
//   a, b      : drive to the unit under test
//   busy      : probe running
//   done      : one-cycle completion pulse
//   valid     : func_code/mismatch hold a completed result
//   func_code : bit i = resp at {a,b}=i during pass 0
//   mismatch  : a later pass disagreed with pass 0
module logicalunit_prober
  import logicalunit_probe_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PASSES        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              resp,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [CODE_W-1:0] func_code,
  output logic              mismatch
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [PASS_W-1:0]   LAST_PASS   = PASS_W'(PASSES - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(3);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  drive_t              drv_d;
  logic                busy_d, done_d, valid_d, mismatch_d;
  logic [CODE_W-1:0]   func_d;
  logic                tmr_load, tmr_en, tmr_expired_c;

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .en         (tmr_en),
    .load_value (SETTLE_LOAD),
    .expired_c  (tmr_expired_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    drv_d      = '0;
    busy_d     = busy;
    done_d     = 1'b0;
    valid_d    = valid;
    func_d     = func_code;
    mismatch_d = mismatch;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // abort in IDLE drops a simultaneous start
        if (start && !abort) begin
          state_d    = SWEEP;
          idx_d      = '0;
          pass_d     = '0;
          busy_d     = 1'b1;
          valid_d    = 1'b0;
          mismatch_d = 1'b0;
          tmr_load   = 1'b1;
          drv_d      = idx_to_drive('0);
        end
      end

      SWEEP: begin
        drv_d = idx_to_drive(idx_q);
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          drv_d   = '0;
        end else if (tmr_expired_c) begin
          // Last edge of this index window: sample resp
          if (pass_q == '0) begin
            func_d[idx_q] = resp;
          end else if (resp != func_code[idx_q]) begin
            mismatch_d = 1'b1;
          end

          if ((idx_q == LAST_IDX) && (pass_q == LAST_PASS)) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b1;
            drv_d   = '0;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              pass_d = pass_q + PASS_W'(1);
            end
            tmr_load = 1'b1;
            drv_d    = idx_to_drive(idx_d);
          end
        end else begin
          tmr_en = 1'b1;
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pass_q    <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      func_code <= '0;
      mismatch  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      a         <= drv_d.a;
      b         <= drv_d.b;
      busy      <= busy_d;
      done      <= done_d;
      valid     <= valid_d;
      func_code <= func_d;
      mismatch  <= mismatch_d;
    end
  end

endmodule

// File: tb/tb_logicalunit_prober.sv
// Bench for logicalunit_prober: two instances (default parameters, and
// SETTLE_CYCLES=0/PASSES=1) each probing a behavioural logical unit.
// Expected results are queued when a probe is issued; a monitor per instance
// pops and compares whenever done pulses.
module tb_logicalunit_prober;
  import logicalunit_probe_pkg::*;

  localparam int unsigned S0 = 1;
  localparam int unsigned P0 = 2;
  localparam int unsigned S1 = 0;
  localparam int unsigned P1 = 1;

  typedef struct {
    logic [3:0]  func;
    logic        mism;
    int unsigned e0;
    int unsigned lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic resp0, resp1;
  logic a0, b0, busy0, done0, valid0, mism0;
  logic a1, b1, busy1, done1, valid1, mism1;
  logic [3:0] code0, code1;
  logic [3:0] func0 = 4'b0000, func1 = 4'b0000;
  logic inv2 = 1'b0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t m0, m1;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural units under test; inv2 models a fault on combination 2
  always_comb resp0 = func0[{a0, b0}] ^ (inv2 && ({a0, b0} == 2'd2));
  always_comb resp1 = func1[{a1, b1}];

  logicalunit_prober #(.SETTLE_CYCLES(S0), .PASSES(P0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .resp(resp0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .valid(valid0),
    .func_code(code0), .mismatch(mism0)
  );

  logicalunit_prober #(.SETTLE_CYCLES(S1), .PASSES(P1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .resp(resp1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .valid(valid1),
    .func_code(code1), .mismatch(mism1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_done0(input int max);
    for (int i = 0; i < max && !done0; i++) @(negedge clk);
    chk("wait_done0", 32'(done0), 32'd1);
  endtask

  task automatic wait_done1(input int max);
    for (int i = 0; i < max && !done1; i++) @(negedge clk);
    chk("wait_done1", 32'(done1), 32'd1);
  endtask

  // Result monitors
  always @(negedge clk) begin
    if (!rst && done0) begin
      if (sb0.size() == 0) begin
        chk("done0_unexpected", 32'(done0), 32'd0);
      end else begin
        m0 = sb0.pop_front();
        chk("func_code0", 32'(code0), 32'(m0.func));
        chk("mismatch0", 32'(mism0), 32'(m0.mism));
        chk("valid0_at_done", 32'(valid0), 32'd1);
        chk("busy0_at_done", 32'(busy0), 32'd0);
        chk("latency0", cyc - m0.e0, m0.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (sb1.size() == 0) begin
        chk("done1_unexpected", 32'(done1), 32'd0);
      end else begin
        m1 = sb1.pop_front();
        chk("func_code1", 32'(code1), 32'(m1.func));
        chk("mismatch1", 32'(mism1), 32'(m1.mism));
        chk("valid1_at_done", 32'(valid1), 32'd1);
        chk("latency1", cyc - m1.e0, m1.lat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_ab0", 32'({a0, b0}), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_valid0", 32'(valid0), 32'd0);
    chk("rst_code0", 32'(code0), 32'd0);
    chk("rst_mism0", 32'(mism0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Probe func=1010 and follow the drive sequence
    func0 = 4'b1010;
    start0 = 1'b1;
    sb0.push_back('{4'b1010, 1'b0, cyc + 1, total_latency(P0, S0)});
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("seq_ab0", 32'({a0, b0}), 32'((k / 2) % 4));
      chk("seq_busy0", 32'(busy0), 32'd1);
      @(negedge clk);
    end
    chk("done0_pulse", 32'(done0), 32'd1);
    @(negedge clk);
    chk("done0_drop", 32'(done0), 32'd0);
    chk("valid0_hold", 32'(valid0), 32'd1);
    chk("busy0_idle", 32'(busy0), 32'd0);
    repeat (2) @(negedge clk);

    // Back-to-back: 0000 then 1111; start held through FINISH
    func0 = 4'b0000;
    start0 = 1'b1;
    sb0.push_back('{4'b0000, 1'b0, cyc + 1, total_latency(P0, S0)});
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(40);
    func0 = 4'b1111;
    start0 = 1'b1;
    sb0.push_back('{4'b1111, 1'b0, cyc + 2, total_latency(P0, S0)});
    @(negedge clk);
    chk("finish_start_ignored", 32'(busy0), 32'd0);
    @(negedge clk);
    start0 = 1'b0;
    chk("b2b_busy0", 32'(busy0), 32'd1);
    chk("b2b_valid0_low", 32'(valid0), 32'd0);
    wait_done0(40);
    repeat (3) @(negedge clk);

    // Fault on {a,b}=2 during pass 1 only
    func0 = 4'b1010;
    start0 = 1'b1;
    sb0.push_back('{4'b1010, 1'b1, cyc + 1, total_latency(P0, S0)});
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(negedge clk);
    inv2 = 1'b1;
    wait_done0(40);
    inv2 = 1'b0;
    repeat (3) @(negedge clk);

    // start while busy, then abort
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    chk("pre_abort_ab0", 32'({a0, b0}), 32'd3);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_busy0", 32'(busy0), 32'd0);
    chk("abort_ab0", 32'({a0, b0}), 32'd0);
    chk("abort_valid0", 32'(valid0), 32'd0);
    chk("abort_done0", 32'(done0), 32'd0);
    repeat (20) @(negedge clk);
    chk("abort_no_restart", 32'(busy0), 32'd0);

    // start and abort together in IDLE
    start0 = 1'b1;
    abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    abort0 = 1'b0;
    chk("idle_abort_wins", 32'(busy0), 32'd0);
    @(negedge clk);

    // Reset mid-sweep, then a clean probe of 0110
    func0 = 4'b1010;
    start0 = 1'b1;
    sb0.push_back('{4'b1010, 1'b0, cyc + 1, total_latency(P0, S0)});
    @(negedge clk);
    start0 = 1'b0;
    void'(sb0.pop_back());
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_ab0", 32'({a0, b0}), 32'd0);
    chk("midrst_busy0", 32'(busy0), 32'd0);
    chk("midrst_code0", 32'(code0), 32'd0);
    chk("midrst_valid0", 32'(valid0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    func0 = 4'b0110;
    start0 = 1'b1;
    sb0.push_back('{4'b0110, 1'b0, cyc + 1, total_latency(P0, S0)});
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(40);
    repeat (2) @(negedge clk);

    // Zero settle, single pass, func=1001
    func1 = 4'b1001;
    start1 = 1'b1;
    sb1.push_back('{4'b1001, 1'b0, cyc + 1, total_latency(P1, S1)});
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("seq_ab1", 32'({a1, b1}), 32'(k));
      @(negedge clk);
    end
    wait_done1(5);
    repeat (3) @(negedge clk);

    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
